// File: rtl/serial_shifter_if.sv
// Start/busy/done handshake bundle between the execute stage and the serial shifter.
// The operation request and the shifted result share one parameterised interface.
interface serial_shifter_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
);
    logic              start;
    logic [1:0]        op;
    logic [WIDTH-1:0]  data;
    logic [AMT_W-1:0]  amount;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;

    modport master (
        output start, op, data, amount,
        input  busy, done, result
    );

    modport slave (
        input  start, op, data, amount,
        output busy, done, result
    );
endinterface

// File: rtl/serial_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROTR unit: shifts the latched operand one bit per clock
// and pulses done for one cycle when the result is valid.
module serial_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    serial_shifter_if.slave    bus
);

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t            state, state_n;
    logic [AMT_W-1:0]  cnt, cnt_n;
    logic [WIDTH-1:0]  acc, acc_n;
    logic [1:0]        op_r, op_n;
    logic              busy_r, busy_n;
    logic              done_r, done_n;

    // Single-bit step of the selected shift.
    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] o);
        logic [WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROTR: r = {v[0], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    // State and datapath registers; busy/done are flopped decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            op_r   <= OP_SLL;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            acc    <= acc_n;
            op_r   <= op_n;
            busy_r <= busy_n;
            done_r <= done_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        acc_n   = acc;
        op_n    = op_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_n   = bus.data;
                    cnt_n   = bus.amount;
                    op_n    = bus.op;
                    state_n = (bus.amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                acc_n = shift1(acc, op_r);
                cnt_n = cnt - AMT_W'(1);
                if (cnt == AMT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = acc;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed and randomized checks of serial_shifter against an arithmetic shift model.
`timescale 1ns/1ps
module tb_serial_shifter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    serial_shifter_if #(.WIDTH(32), .AMT_W(5)) bus ();

    serial_shifter #(.WIDTH(32), .AMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result computed directly from the shift definitions.
    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] d, input int n);
        logic [63:0] dd;
        case (o)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return 32'($signed(d) >>> n);
            default: begin
                dd = {d, d} >> n;
                return dd[31:0];
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble inputs after acceptance, then check latency and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] n, input string tag);
        logic [31:0] exp;
        int cyc;
        exp = ref_model(o, d, int'(n));
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.data   = d;
        bus.amount = n;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op     = 2'($urandom);
        bus.data   = $urandom;
        bus.amount = 5'($urandom);
        chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(n));
        chk({tag, "_result"}, bus.result, exp);
        @(posedge clk);
        #1;
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done_fall"}, 32'(bus.done), 32'd0);
        chk({tag, "_hold"}, bus.result, exp);
    endtask

    initial begin
        int cyc;
        int done_seen;
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.data   = '0;
        bus.amount = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        // Directed cases.
        run_op(2'b00, 32'h0000_0001, 5'd4,  "sll4");
        chk("sll4_val", bus.result, 32'h0000_0010);
        run_op(2'b00, 32'h0000_0001, 5'd31, "sll31");
        chk("sll31_val", bus.result, 32'h8000_0000);
        run_op(2'b01, 32'h8000_0000, 5'd31, "srl31");
        chk("srl31_val", bus.result, 32'h0000_0001);
        run_op(2'b10, 32'h8000_0000, 5'd31, "sra31");
        chk("sra31_val", bus.result, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h7FFF_FFF0, 5'd4,  "sra4");
        chk("sra4_val", bus.result, 32'h07FF_FFFF);
        run_op(2'b11, 32'h0000_0001, 5'd1,  "rotr1");
        chk("rotr1_val", bus.result, 32'h8000_0000);
        run_op(2'b11, 32'h1234_5678, 5'd8,  "rotr8");
        chk("rotr8_val", bus.result, 32'h7812_3456);
        for (int o = 0; o < 4; o++) begin
            run_op(2'(o), 32'hDEAD_BEEF, 5'd0, "zero_amt");
            chk("zero_amt_val", bus.result, 32'hDEAD_BEEF);
        end

        // Start while busy must be ignored.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.data   = 32'h0000_0001;
        bus.amount = 5'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (cyc == 2) begin
                bus.start  = 1'b1;
                bus.data   = 32'hFFFF_FFFF;
                bus.amount = 5'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        chk("busy_start_latency", 32'(cyc), 32'd5);
        chk("busy_start_result", bus.result, 32'h0000_0020);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        chk("busy_start_single_done", 32'(done_seen), 32'd0);
        chk("busy_start_hold", bus.result, 32'h0000_0020);

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.data   = 32'hA5A5_A5A5;
        bus.amount = 5'd20;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_result", bus.result, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_hold_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b00, 32'h0000_0003, 5'd2, "after_rst");

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), $urandom, 5'($urandom), "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
